mdu: RTL and testbench

- Parametrised multiply/divide unit (RV32M/RV64M semantics). Sits beside the combinational alu in the execute stage.
- Runs all eight M-extension ops iteratively, BITS_PER_CYCLE result bits per cycle.
- Valid/ready handshakes on both input and output, plus a kill input for pipeline flushes.

---
 rtl/mdu.sv | 208 ++++++++++++++++++++
 tb/tb_mdu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes and kill.
// Optional macro MDU_MUL_1CYC_EN: single-cycle combinational multiplier for ops 0-3.
module mdu #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      mdu_op,
    input  logic [XLEN-1:0] mdu_in1,
    input  logic [XLEN-1:0] mdu_in2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] mdu_out,
    output logic            busy
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    state_t              state_nx;
    logic [CW-1:0]       cnt;
    logic [2:0]          op_q;
    logic                res_neg;
    logic [XLEN-1:0]     divisor;
    logic [2*XLEN-1:0]   acc;

    logic                accept;
    logic                sgn1;
    logic                sgn2;
    logic                neg1;
    logic                neg2;
    logic [XLEN-1:0]     mag1;
    logic [XLEN-1:0]     mag2;
    logic                div_zero;
    logic                div_ovf;
    logic                special;
    logic [XLEN-1:0]     special_res;
    logic                fast_mul;
    logic [XLEN-1:0]     fast_res;

    logic [2*XLEN-1:0]   acc_step;
    logic [XLEN:0]       rem_sh;
    logic [XLEN:0]       diff;
    logic [XLEN:0]       sum;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix;
    logic [XLEN-1:0]     rem_fix;
    logic [XLEN-1:0]     calc_res;

    assign accept = (state == IDLE) && in_valid && !kill;

    // Operand decode: signedness per op, magnitudes and the divide special cases.
    always_comb begin
        sgn1 = (mdu_op == 3'd1) || (mdu_op == 3'd2) || (mdu_op == 3'd4) || (mdu_op == 3'd6);
        sgn2 = (mdu_op == 3'd1) || (mdu_op == 3'd4) || (mdu_op == 3'd6);
        neg1 = sgn1 && mdu_in1[XLEN-1];
        neg2 = sgn2 && mdu_in2[XLEN-1];
        mag1 = neg1 ? -mdu_in1 : mdu_in1;
        mag2 = neg2 ? -mdu_in2 : mdu_in2;
        div_zero = mdu_op[2] && (mdu_in2 == '0);
        div_ovf  = mdu_op[2] && !mdu_op[0]
                   && (mdu_in1 == {1'b1, {(XLEN-1){1'b0}}})
                   && (mdu_in2 == '1);
        special  = div_zero || div_ovf;
        special_res = '1;
        if (div_ovf) begin
            special_res = mdu_op[1] ? '0 : mdu_in1;
        end else if (mdu_op[1]) begin
            special_res = mdu_in1;
        end
    end

`ifdef MDU_MUL_1CYC_EN
    logic [2*XLEN-1:0] fast_prod;
    logic [2*XLEN-1:0] fast_fix;

    always_comb begin
        fast_mul  = !mdu_op[2];
        fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
        fast_fix  = (neg1 ^ neg2) ? -fast_prod : fast_prod;
        fast_res  = (mdu_op == 3'd0) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
    end
`else
    assign fast_mul = 1'b0;
    assign fast_res = '0;
`endif

    // One compute cycle: BITS_PER_CYCLE shift-add or restoring-divide sub-steps.
    always_comb begin
        acc_step = acc;
        rem_sh   = '0;
        diff     = '0;
        sum      = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q[2]) begin
                rem_sh = acc_step[2*XLEN-1:XLEN-1];
                diff   = rem_sh - {1'b0, divisor};
                if (!diff[XLEN]) begin
                    acc_step = {diff[XLEN-1:0], acc_step[XLEN-2:0], 1'b1};
                end else begin
                    acc_step = {acc_step[2*XLEN-2:0], 1'b0};
                end
            end else begin
                sum      = {1'b0, acc_step[2*XLEN-1:XLEN]} + (acc_step[0] ? {1'b0, divisor} : '0);
                acc_step = {sum, acc_step[XLEN-1:1]};
            end
        end
    end

    // Sign fix-up applied to the final step's value as it is written to mdu_out.
    always_comb begin
        prod_fix = res_neg ? -acc_step : acc_step;
        quo_fix  = res_neg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem_fix  = res_neg ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
        case (op_q)
            3'd0:          calc_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          calc_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:    calc_res = quo_fix;
            default:       calc_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = !kill;
                if (accept) begin
                    state_nx = (special || fast_mul) ? DONE : CALC;
                end
            end
            CALC: begin
                if (kill) begin
                    state_nx = IDLE;
                end else if (cnt == CW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (kill || out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Both multiply and divide start from {0, |in1|}; divisor doubles as multiplicand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            op_q    <= '0;
            res_neg <= 1'b0;
            divisor <= '0;
            acc     <= '0;
            mdu_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= mdu_op;
                        res_neg <= (mdu_op == 3'd6) ? neg1 : (neg1 ^ neg2);
                        divisor <= mag2;
                        acc     <= {{XLEN{1'b0}}, mag1};
                        cnt     <= CW'(N);
                        if (special) begin
                            mdu_out <= special_res;
                        end else if (fast_mul) begin
                            mdu_out <= fast_res;
                        end
                    end
                end
                CALC: begin
                    if (!kill) begin
                        cnt <= cnt - CW'(1);
                        acc <= acc_step;
                        if (cnt == CW'(1)) begin
                            mdu_out <= calc_res;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed corner cases, handshake/kill/reset tests,
// and randomized operations checked against a plain-arithmetic reference model.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  mdu_op;
    logic [31:0] mdu_in1;
    logic [31:0] mdu_in2;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] mdu_out;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic saw_ready;
    logic hold_bad;

    mdu #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mdu_op    (mdu_op),
        .mdu_in1   (mdu_in1),
        .mdu_in2   (mdu_in2),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mdu_out   (mdu_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = 0;
        case (op)
            3'd0: p = ua * ub;
            3'd1: p = sa * sb;
            3'd2: p = sa * ub;
            3'd3: p = ua * ub;
            default: ;
        endcase
        if (op == 3'd0) return p[31:0];
        if (!op[2]) return p[63:32];
        if (b == 32'd0) return op[1] ? a : 32'hFFFFFFFF;
        if (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return op[1] ? 32'd0 : a;
        case (op)
            3'd4: p = sa / sb;
            3'd5: p = ua / ub;
            3'd6: p = sa % sb;
            default: p = ua % ub;
        endcase
        return p[31:0];
    endfunction

    // Edges after the accept edge before out_valid is seen (0 = valid in the very next cycle).
    function automatic int expLat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 32'd0)) return 0;
        if (op[2] && !op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
`ifdef MDU_MUL_1CYC_EN
        if (!op[2]) return 0;
`endif
        return 32;
    endfunction

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input int hold, output logic [31:0] res, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) checkOutput("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        mdu_op   = op;
        mdu_in1  = a;
        mdu_in2  = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        saw_ready = 1'b0;
        hold_bad  = 1'b0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            if (in_ready) saw_ready = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = mdu_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b1 || mdu_out !== res || in_ready !== 1'b0) hold_bad = 1'b1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    logic [2:0]  d_op [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] d_a  [12] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                               32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] d_b  [12] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                               32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] d_x  [12] = '{32'hFFFFFFEB, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                               32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res;
        logic [31:0] a, b;
        logic [2:0]  op;
        int lat;
        logic leak;

        rst_n = 1'b0; in_valid = 1'b0; mdu_op = '0; mdu_in1 = '0; mdu_in2 = '0;
        kill = 1'b0; out_ready = 1'b0;
        #12;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_mdu_out", 64'(mdu_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(d_op[i], d_a[i], d_b[i], 0, res, lat);
            checkOutput($sformatf("dir%0d_res", i), 64'(res), 64'(d_x[i]));
            checkOutput($sformatf("dir%0d_lat", i), 64'(lat), 64'(expLat(d_op[i], d_a[i], d_b[i])));
            if (expLat(d_op[i], d_a[i], d_b[i]) != 0)
                checkOutput($sformatf("dir%0d_ready_low", i), 64'(saw_ready), 64'd0);
        end

        applyStimulus(3'd4, 32'd1000, 32'd7, 10, res, lat);
        checkOutput("bp_res", 64'(res), 64'd142);
        checkOutput("bp_hold", 64'(hold_bad), 64'd0);
        @(negedge clk);
        checkOutput("bp_idle_valid", 64'(out_valid), 64'd0);
        checkOutput("bp_idle_ready", 64'(in_ready), 64'd1);

        in_valid = 1'b1; kill = 1'b1; mdu_op = 3'd0; mdu_in1 = 32'd3; mdu_in2 = 32'd4;
        #1 checkOutput("kill_idle_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0; kill = 1'b0;
        @(negedge clk);
        checkOutput("kill_idle_busy", 64'(busy), 64'd0);

        in_valid = 1'b1; mdu_op = 3'd0; mdu_in1 = 32'd123; mdu_in2 = 32'd456;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        checkOutput("kill_calc_valid", 64'(out_valid), 64'd0);
        checkOutput("kill_calc_busy", 64'(busy), 64'd0);
        checkOutput("kill_calc_ready", 64'(in_ready), 64'd1);
        leak = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) leak = 1'b1;
        end
        checkOutput("kill_no_result", 64'(leak), 64'd0);
        applyStimulus(3'd4, 32'd9, 32'd3, 0, res, lat);
        checkOutput("after_kill_div", 64'(res), 64'd3);

        @(negedge clk);
        in_valid = 1'b1; mdu_op = 3'd5; mdu_in1 = 32'd77; mdu_in2 = 32'd5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", 64'(out_valid), 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_mdu_out", 64'(mdu_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 checkOutput("arst_ready", 64'(in_ready), 64'd1);
        applyStimulus(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, res, lat);
        checkOutput("arst_then_mulhu", 64'(res), 64'hFFFFFFFE);

        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pickOperand();
            b  = pickOperand();
            applyStimulus(op, a, b, $urandom_range(0, 3), res, lat);
            checkOutput($sformatf("rnd%0d_op%0d_res", i, op), 64'(res), 64'(refModel(op, a, b)));
            checkOutput($sformatf("rnd%0d_op%0d_lat", i, op), 64'(lat), 64'(expLat(op, a, b)));
            checkOutput($sformatf("rnd%0d_hold", i), 64'(hold_bad), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
